// File: rtl/m10k_mat_writer.sv
// Snapshots an M x N matrix on start and streams rows to an M10K write port; ZERO_ROW_SKIP_EN drops all-zero rows.
// Latency: first beat one cycle after the start edge, one row per accepted beat, DONE one cycle after the last row.
// Backpressure: beat, address and row index hold while i_wr_ready is low; valid never drops until the beat is accepted.
module m10k_mat_writer #(
    parameter int DATA_LEN     = 32,
    parameter int M            = 8,
    parameter int N            = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int OFFSET       = 0,
    parameter int ROW_W        = $clog2(M + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_write_start,
    input  logic [DATA_LEN*M*N-1:0]    i_in_mat,
    input  logic [ADDRESS_SIZE-1:0]    i_base_addr,
    input  logic [ROW_W-1:0]           i_num_rows,
    input  logic                       i_wr_ready,
    output logic [ADDRESS_SIZE-1:0]    o_write_addr,
    output logic [DATA_LEN*N-1:0]      o_write_data,
    output logic                       o_write_valid,
    output logic [1:0]                 o_state,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [M-1:0]               o_row_mask
);

    localparam int ROW_BITS = DATA_LEN * N;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ROW_BITS-1:0]     snap [M];
    logic [ROW_W-1:0]        idx;
    logic [ROW_W-1:0]        n_q;
    logic [ADDRESS_SIZE-1:0] base_q;
    logic [M-1:0]            row_mask;

    logic [ROW_BITS-1:0]     row_cur;
    logic [M-1:0]            row_onehot;
    logic [ROW_W-1:0]        num_clamp;
    logic                    in_write;
    logic                    row_zero;
    logic                    advance;
    logic                    accept;
    logic                    last_row;

    assign num_clamp = (i_num_rows > ROW_W'(M)) ? ROW_W'(M) : i_num_rows;
    assign in_write  = (state == S_WRITE);
    assign last_row  = (idx == n_q - ROW_W'(1));

    always_comb begin
        row_cur    = '0;
        row_onehot = '0;
        for (int r = 0; r < M; r++) begin
            if (idx == ROW_W'(r)) begin
                row_cur       = snap[r];
                row_onehot[r] = 1'b1;
            end
        end
    end

`ifdef ZERO_ROW_SKIP_EN
    // An all-zero row is retired in one cycle with no beat, so it never waits on the port.
    assign row_zero = (row_cur == '0);
`else
    assign row_zero = 1'b0;
`endif

    assign accept  = in_write && !row_zero && i_wr_ready;
    assign advance = in_write && (row_zero || i_wr_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_write_start) state_nxt = (num_clamp == '0) ? S_DONE : S_WRITE;
            S_WRITE: if (advance && last_row) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx      <= '0;
            n_q      <= '0;
            base_q   <= '0;
            row_mask <= '0;
            for (int r = 0; r < M; r++) snap[r] <= '0;
        end else if (state == S_IDLE) begin
            if (i_write_start) begin
                for (int r = 0; r < M; r++) snap[r] <= i_in_mat[ROW_BITS*r +: ROW_BITS];
                base_q   <= i_base_addr;
                n_q      <= num_clamp;
                idx      <= '0;
                row_mask <= '0;
            end
        end else if (in_write) begin
            if (accept)  row_mask <= row_mask | row_onehot;
            if (advance) idx      <= idx + ROW_W'(1);
        end
    end

    // Outputs decode registered state only; i_wr_ready reaches flops, never ports.
    always_comb begin
        o_state       = state;
        o_busy        = in_write;
        o_done        = (state == S_DONE);
        o_write_valid = in_write && !row_zero;
        o_write_addr  = in_write ? (base_q + ADDRESS_SIZE'(OFFSET) + ADDRESS_SIZE'(idx)) : '0;
        o_write_data  = in_write ? row_cur : '0;
        o_row_mask    = row_mask;
    end

endmodule

// File: doc/m10k_mat_writer.md
Name: m10k_mat_writer

Overview:
- Parametrised successor to the fixed 8-row M10K matrix writer.
- Snapshots an M x N matrix on a start pulse and streams rows (N words of DATA_LEN bits each) to an M10K write port with a valid/ready handshake.
- Supports a runtime base address and row count, and signals completion.
- Sits between the SpMV matrix loader and the M10K bank arbiter.

Parameters:
DATA_LEN, 32, bits per matrix element
M, 8, maximum rows per matrix (>=1)
N, 8, elements per row
ADDRESS_SIZE, 4, M10K address width
OFFSET, 0, constant address added to every write
ROW_W, $clog2(M+1), width of row-count fields (derived, do not override)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset; one clock, reset is synchronous and active-high
i_write_start  in  1  start pulse, sampled only in IDLE
i_in_mat  in  DATA_LEN*M*N  matrix; row r = i_in_mat[DATA_LEN*N*r +: DATA_LEN*N]
i_base_addr  in  ADDRESS_SIZE  first row address, sampled with start
i_num_rows  in  ROW_W  rows to write, sampled with start
i_wr_ready  in  1  M10K port accepts the current beat
o_write_addr  out  ADDRESS_SIZE  write address
o_write_data  out  DATA_LEN*N  write row
o_write_valid  out  1  beat valid
o_state  out  2  IDLE=0, WRITE=1, DONE=2
o_busy  out  1  high in WRITE
o_done  out  1  one-cycle pulse in DONE
o_row_mask  out  M  bit r set once row r has been accepted

Behaviour:
- Reset (synchronous, active-high), takes priority over all else: state=IDLE, row index=0, snapshot regs=0, o_row_mask=0. Outputs are then o_write_valid=0, o_write_addr=0, o_write_data=0, o_busy=0, o_done=0, o_state=0.
- A reset asserted mid-WRITE aborts the transfer; no valid beat appears in the next cycle.
- IDLE, i_write_start=1 at edge t:
  - Capture i_in_mat, i_base_addr and n = min(i_num_rows, M).
  - Clear row index and o_row_mask.
  - If n==0, go to DONE; otherwise go to WRITE, with the first valid beat visible in cycle t+1.
- WRITE:
  - o_write_valid=1.
  - o_write_data = snapshot row[idx].
  - o_write_addr = (base + OFFSET + idx) mod 2^ADDRESS_SIZE; addresses wrap silently.
  - Beat accepted when valid && i_wr_ready at an edge: set o_row_mask[idx], then idx++. If idx was n-1, go to DONE.
  - Without i_wr_ready, addr, data and idx hold stable; valid never drops once raised until the beat is accepted.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_row_mask holds until the next accepted start or reset.
- i_write_start in WRITE or DONE is ignored; it is not queued.
- Input matrix changes after the start cycle do not affect the written data.
- Outputs are combinational decodes of registered state, idx and snapshot; there are no combinational paths from i_wr_ready or i_in_mat to any output.
- Back-to-back: start asserted in the IDLE cycle immediately after DONE is accepted.

Optional Feature:
ZERO_ROW_SKIP_EN
- Defined:
  - In WRITE, if snapshot row[idx] is all-zero, o_write_valid=0 and idx advances that cycle without waiting for i_wr_ready. The mask bit stays 0.
  - If a skipped row is the last row, go to DONE.
  - Non-zero rows keep their positional address (base+OFFSET+idx).
- Undefined:
  - Every row 0..n-1 is written.
  - After DONE, o_row_mask equals the low n bits set.

Test Plan:
1. M=8, N=8, base=0, num_rows=8, i_wr_ready=1, row r filled with value r+1 -> 8 beats on consecutive cycles, addr 0..7, then o_done one cycle later; mask=0xFF.
2. base=14, num_rows=4, ADDRESS_SIZE=4 -> addresses 14, 15, 0, 1 (wrap); o_done after the 4th accepted beat.
3. num_rows=3; i_wr_ready low for 2 cycles on beat 1 -> beat 1 addr/data held stable for 3 cycles; 3 beats total; mask=0x07.
4. num_rows=0 -> no valid beat; o_done at cycle t+1; num_rows=9 with M=8 -> exactly 8 beats.
5. Start pulsed again mid-WRITE, and i_in_mat changed at the same time -> ignored; data equals the start-cycle snapshot. i_rst asserted after beat 2 -> the next cycle is IDLE with all outputs 0.
6. With ZERO_ROW_SKIP_EN and rows 1 and 5 zero, num_rows=8 -> 6 beats at addrs 0, 2, 3, 4, 6, 7; mask=0xDD; without the macro -> 8 beats, mask=0xFF.
